// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the icache and the dcache and
// splits each 256-bit line transfer into four 64-bit beats.
//
// state | meaning
// IDLE  | waiting for a request; round-robin grant on tie
// READ  | mem_read burst, beats assembled into grantee's rdata register
// WRITE | mem_write burst, beats taken from the latched line
// DONE  | one-cycle resp pulse to the grantee
module pmem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_pmem_address,
  input  logic         i_pmem_read,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic [31:0]  d_pmem_address,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  logic [1:0]   state;
  logic         grant;
  logic         last;
  logic [1:0]   beat;
  logic [31:0]  addr_q;
  logic [255:0] wdata_q;
  logic [255:0] i_rdata_q;
  logic [255:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) pick_d = (last == GRANT_I);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= GRANT_I;
      last      <= GRANT_D;
      beat      <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant <= pick_d;
            last  <= pick_d;
            beat  <= 2'd0;
            if (pick_d) begin
              addr_q  <= d_pmem_address & LINE_MASK;
              wdata_q <= d_pmem_wdata;
              // write wins if the dcache raises both strobes
              state   <= d_pmem_write ? WRITE : READ;
            end else begin
              addr_q <= i_pmem_address & LINE_MASK;
              state  <= READ;
            end
          end
        end
        READ: begin
          if (mem_resp) begin
            if (grant == GRANT_D) d_rdata_q[{beat, 6'b0} +: 64] <= mem_rdata;
            else                  i_rdata_q[{beat, 6'b0} +: 64] <= mem_rdata;
            beat <= beat + 2'd1;
            if (beat == 2'd3) state <= DONE;
          end
        end
        WRITE: begin
          if (mem_resp) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read     = (state == READ);
  assign mem_write    = (state == WRITE);
  assign mem_address  = addr_q;
  assign mem_wdata    = (state == WRITE) ? wdata_q[{beat, 6'b0} +: 64] : 64'd0;
  assign i_pmem_resp  = (state == DONE) && (grant == GRANT_I);
  assign d_pmem_resp  = (state == DONE) && (grant == GRANT_D);
  assign i_pmem_rdata = i_rdata_q;
  assign d_pmem_rdata = d_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: inputs driven and outputs sampled on the
// falling edge, memory side modelled by the burst task below.
module tb_pmem_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_read;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [31:0]  d_pmem_address;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int errors = 0;
  int checks = 0;

  pmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge where the request is (or already was) visible.
  // Waits for the strobe, serves four beats with gaps[4b+3:4b] idle cycles
  // before beat b, and returns on the falling edge of the DONE cycle.
  task automatic burst(input string tag, input logic exp_write, input logic exp_d,
                       input logic [31:0] exp_addr, input logic [255:0] line,
                       input logic [15:0] gaps, input int exp_wait);
    int waited;
    waited = 1;
    @(negedge clk);
    while (!(mem_read || mem_write) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_strobe_seen"}, 256'(mem_read | mem_write), 256'(1));
    chk({tag, "_strobe_delay"}, 256'(waited), 256'(exp_wait));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g <= int'(gaps[4*b +: 4]); g++) begin
        mem_resp  = (g == int'(gaps[4*b +: 4]));
        mem_rdata = mem_resp ? line[64*b +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
        chk({tag, "_mem_read"}, 256'(mem_read), 256'(!exp_write));
        chk({tag, "_mem_write"}, 256'(mem_write), 256'(exp_write));
        chk({tag, "_mem_address"}, 256'(mem_address), 256'(exp_addr));
        if (exp_write) chk({tag, "_mem_wdata"}, 256'(mem_wdata), 256'(line[64*b +: 64]));
        @(negedge clk);
      end
    end
    mem_resp  = 1'b0;
    mem_rdata = 64'd0;
    chk({tag, "_done_i_resp"}, 256'(i_pmem_resp), 256'(!exp_d));
    chk({tag, "_done_d_resp"}, 256'(d_pmem_resp), 256'(exp_d));
    chk({tag, "_done_strobes"}, 256'({mem_read, mem_write}), 256'(0));
  endtask

  logic [255:0] line_a;
  logic [255:0] line_d;
  logic [255:0] line_b;
  logic [255:0] line_c;
  logic [255:0] line_e;

  initial begin
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_d = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    line_b = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
              64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    line_c = {64'hC3C3_1111_2222_3333, 64'hC2C2_4444_5555_6666,
              64'hC1C1_7777_8888_9999, 64'hC0C0_AAAA_BBBB_CCCC};
    line_e = {64'hE3E3_E3E3_0000_0001, 64'hE2E2_E2E2_0000_0002,
              64'hE1E1_E1E1_0000_0003, 64'hE0E0_E0E0_0000_0004};

    rst = 1'b1;
    i_pmem_address = 32'd0; i_pmem_read = 1'b0;
    d_pmem_address = 32'd0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_wdata = '0; mem_rdata = 64'd0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_strobes", 256'({mem_read, mem_write}), 256'(0));
    chk("reset_addr", 256'(mem_address), 256'(0));
    chk("reset_wdata", 256'(mem_wdata), 256'(0));
    chk("reset_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    chk("reset_i_rdata", i_pmem_rdata, 256'(0));
    chk("reset_d_rdata", d_pmem_rdata, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // icache read, back-to-back beats
    i_pmem_address = 32'h0000_1234; i_pmem_read = 1'b1;
    burst("iread", 1'b0, 1'b0, 32'h0000_1220, line_a, 16'h0000, 1);
    i_pmem_read = 1'b0;
    chk("iread_rdata", i_pmem_rdata, line_a);
    chk("iread_d_rdata", d_pmem_rdata, 256'(0));
    @(negedge clk);
    chk("iread_resp_once", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));

    // dcache writeback
    d_pmem_address = 32'h8000_0040; d_pmem_write = 1'b1; d_pmem_wdata = line_d;
    burst("dwrite", 1'b1, 1'b1, 32'h8000_0040, line_d, 16'h0000, 1);
    d_pmem_write = 1'b0;
    chk("dwrite_d_rdata", d_pmem_rdata, 256'(0));
    @(negedge clk);
    chk("dwrite_resp_once", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));

    // tie: I first, queued D strobe two cycles after i resp
    i_pmem_address = 32'h0000_0100; i_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0200; d_pmem_read = 1'b1;
    burst("tie1_i", 1'b0, 1'b0, 32'h0000_0100, line_b, 16'h0000, 1);
    i_pmem_read = 1'b0;
    i_pmem_address = 32'hFFFF_FFFF;
    burst("tie1_d", 1'b0, 1'b1, 32'h0000_0200, line_c, 16'h0000, 2);
    d_pmem_read = 1'b0;
    chk("tie1_i_rdata", i_pmem_rdata, line_b);
    chk("tie1_d_rdata", d_pmem_rdata, line_c);
    @(negedge clk);

    // second tie serves I again; I burst with stalled memory 0/3/1/5
    i_pmem_address = 32'h0000_0300; i_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0400; d_pmem_read = 1'b1;
    burst("tie2_i_stall", 1'b0, 1'b0, 32'h0000_0300, line_e, 16'h5130, 1);
    i_pmem_read = 1'b0;
    burst("tie2_d", 1'b0, 1'b1, 32'h0000_0400, line_a, 16'h0000, 2);
    d_pmem_read = 1'b0;
    chk("stall_i_rdata", i_pmem_rdata, line_e);
    chk("tie2_d_rdata", d_pmem_rdata, line_a);
    @(negedge clk);
    chk("tie2_resp_once", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));

    // reset after beat 2 of a dcache write
    d_pmem_address = 32'h0000_0800; d_pmem_write = 1'b1; d_pmem_wdata = line_d;
    @(negedge clk);
    chk("rstmid_strobe", 256'(mem_write), 256'(1));
    for (int b = 0; b < 3; b++) begin
      mem_resp = 1'b1;
      @(negedge clk);
    end
    mem_resp = 1'b0; rst = 1'b1; d_pmem_write = 1'b0;
    @(negedge clk);
    chk("rstmid_strobes", 256'({mem_read, mem_write}), 256'(0));
    chk("rstmid_addr", 256'(mem_address), 256'(0));
    chk("rstmid_wdata", 256'(mem_wdata), 256'(0));
    chk("rstmid_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    chk("rstmid_i_rdata", i_pmem_rdata, 256'(0));
    chk("rstmid_d_rdata", d_pmem_rdata, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // fresh icache read after reset
    i_pmem_address = 32'h0000_0A1F; i_pmem_read = 1'b1;
    burst("post_rst_i", 1'b0, 1'b0, 32'h0000_0A00, line_c, 16'h0000, 1);
    i_pmem_read = 1'b0;
    chk("post_rst_i_rdata", i_pmem_rdata, line_c);
    @(negedge clk);

    // illegal read+write from dcache performs a write
    d_pmem_address = 32'h1234_567F; d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_wdata = line_b;
    burst("illegal_rw", 1'b1, 1'b1, 32'h1234_5660, line_b, 16'h0000, 1);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    chk("illegal_d_rdata", d_pmem_rdata, 256'(0));
    chk("illegal_i_rdata", i_pmem_rdata, line_c);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
